reg_file_sb: RTL and testbench

Parametrised multi-read-port general-purpose register file with a write-back bypass and a per-register busy scoreboard. It sits between decode/issue and write-back in the pipelined core. It provides operand data plus per-operand ready flags, so issue logic can detect RAW hazards and block WAW issue without a separate hazard unit. Register x0 is hard-wired to zero and never busy.

---
 rtl/reg_file_pkg.sv | 14 +
 rtl/reg_scoreboard.sv | 51 +++++
 rtl/reg_file_sb.sv | 85 ++++++++
 tb/tb_reg_file_sb.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_file_pkg.sv
// Shared definitions for the general-purpose register file and its scoreboard.
package reg_file_pkg;

    localparam int GEN_REG_COUNT  = 32;
    localparam int REG_ADDR_WIDTH = 5;

    typedef logic [REG_ADDR_WIDTH-1:0] reg_addr_t;

    // x0 is hard-wired to zero: never stored, never busy.
    function automatic logic reg_is_zero(input reg_addr_t addr);
        return (addr == '0);
    endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Per-register busy scoreboard: accepts issues, clears on write-back and
// exposes the busy vector. A same-cycle write-back and issue to the same
// register leaves the bit set because the newly issued producer is pending.
module reg_scoreboard
    import reg_file_pkg::*;
(
    input  logic        clk_in,
    input  logic        reset,
    input  logic        issue_en_in,
    input  logic [4:0]  issue_rd_in,
    input  logic        wb_en_in,
    input  logic [4:0]  wb_rd_in,
    output logic        issue_ready_out,
    output logic [31:0] busy_out
);

    logic [GEN_REG_COUNT-1:0] busy_q;
    logic [GEN_REG_COUNT-1:0] busy_d;
    logic                     issue_accept;

    // Issue is allowed when the destination is free or is being freed this cycle.
    always_comb begin
        issue_ready_out = reg_is_zero(issue_rd_in) || !busy_q[issue_rd_in] ||
                          (wb_en_in && (wb_rd_in == issue_rd_in));
        issue_accept    = issue_en_in && issue_ready_out;
    end

    // Next busy vector: clear on write-back first, then set on issue so the new producer wins.
    always_comb begin
        busy_d = busy_q;
        if (wb_en_in && !reg_is_zero(wb_rd_in)) begin
            busy_d[wb_rd_in] = 1'b0;
        end
        if (issue_accept && !reg_is_zero(issue_rd_in)) begin
            busy_d[issue_rd_in] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    // Busy-bit register with synchronous clear.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy_out = busy_q;

endmodule

// File: rtl/reg_file_sb.sv
// Multi-read-port register file with optional write-back bypass and a busy
// scoreboard, giving issue logic operand data plus per-operand ready flags.
module reg_file_sb
    import reg_file_pkg::*;
#(
    parameter int REG_DATA_WIDTH_POW = 6,
    parameter int NUM_READ_PORTS     = 2,
    parameter int BYPASS_EN          = 1
) (
    input  logic                                            clk_in,
    input  logic                                            reset,
    input  logic [NUM_READ_PORTS*5-1:0]                     rs_addr_in,
    output logic [NUM_READ_PORTS*(1<<REG_DATA_WIDTH_POW)-1:0] rs_data_out,
    output logic [NUM_READ_PORTS-1:0]                       rs_ready_out,
    input  logic                                            issue_en_in,
    input  logic [4:0]                                      issue_rd_in,
    output logic                                            issue_ready_out,
    input  logic                                            wb_en_in,
    input  logic [4:0]                                      wb_rd_in,
    input  logic [(1<<REG_DATA_WIDTH_POW)-1:0]              wb_data_in,
    output logic [31:0]                                     busy_out
);

    localparam int   DW  = 1 << REG_DATA_WIDTH_POW;
    localparam logic BYP = (BYPASS_EN != 0);

    logic [DW-1:0]            regs_q [GEN_REG_COUNT];
    logic [DW-1:0]            regs_d [GEN_REG_COUNT];
    logic [GEN_REG_COUNT-1:0] busy;

    reg_scoreboard u_scoreboard (
        .clk_in          (clk_in),
        .reset           (reset),
        .issue_en_in     (issue_en_in),
        .issue_rd_in     (issue_rd_in),
        .wb_en_in        (wb_en_in),
        .wb_rd_in        (wb_rd_in),
        .issue_ready_out (issue_ready_out),
        .busy_out        (busy)
    );

    assign busy_out = busy;

    // Next data array: write-back updates one register; writes to x0 are dropped.
    always_comb begin
        regs_d = regs_q;
        if (wb_en_in && !reg_is_zero(wb_rd_in)) begin
            regs_d[wb_rd_in] = wb_data_in;
        end
    end

    // Data array storage with synchronous clear.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            regs_q <= '{default: '0};
        end else begin
            regs_q <= regs_d;
        end
    end

    for (genvar p = 0; p < NUM_READ_PORTS; p++) begin : g_rd
        reg_addr_t     addr;
        logic [DW-1:0] data;
        logic          ready;

        assign addr = rs_addr_in[p*REG_ADDR_WIDTH +: REG_ADDR_WIDTH];

        // Read mux: x0 first, then same-cycle write-back forward, then stored value.
        always_comb begin
            data  = regs_q[addr];
            ready = !busy[addr];
            if (reg_is_zero(addr)) begin
                data  = '0;
                ready = 1'b1;
            end else if (BYP && wb_en_in && (wb_rd_in == addr)) begin
                data  = wb_data_in;
                ready = 1'b1;
            end
        end

        assign rs_data_out[p*DW +: DW] = data;
        assign rs_ready_out[p]         = ready;
    end

endmodule

// File: tb/tb_reg_file_sb.sv
// Bench for reg_file_sb: a directed vector table for the default build, a
// short sequence for the non-bypass 3-port build, and randomized traffic
// against an array-based reference model shared by both instances.
module tb_reg_file_sb;

    logic         clk;
    logic         rst;
    logic         ie;
    logic [4:0]   ir;
    logic         we;
    logic [4:0]   wr;
    logic [63:0]  wd;

    logic [9:0]   a_addr;
    logic [127:0] a_data;
    logic [1:0]   a_rdy;
    logic         a_iss;
    logic [31:0]  a_busy;

    logic [14:0]  n_addr;
    logic [191:0] n_data;
    logic [2:0]   n_rdy;
    logic         n_iss;
    logic [31:0]  n_busy;

    int checks = 0;
    int errors = 0;

    logic [63:0] m_data [32];
    bit          m_busy [32];

    reg_file_sb dut (
        .clk_in(clk), .reset(rst), .rs_addr_in(a_addr), .rs_data_out(a_data),
        .rs_ready_out(a_rdy), .issue_en_in(ie), .issue_rd_in(ir),
        .issue_ready_out(a_iss), .wb_en_in(we), .wb_rd_in(wr), .wb_data_in(wd),
        .busy_out(a_busy)
    );

    reg_file_sb #(.REG_DATA_WIDTH_POW(6), .NUM_READ_PORTS(3), .BYPASS_EN(0)) dut_nb (
        .clk_in(clk), .reset(rst), .rs_addr_in(n_addr), .rs_data_out(n_data),
        .rs_ready_out(n_rdy), .issue_en_in(ie), .issue_rd_in(ir),
        .issue_ready_out(n_iss), .wb_en_in(we), .wb_rd_in(wr), .wb_data_in(wd),
        .busy_out(n_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        r;
        logic        ie;
        logic [4:0]  ir;
        logic        we;
        logic [4:0]  wr;
        logic [63:0] wd;
        logic [4:0]  a0;
        logic [4:0]  a1;
        logic [63:0] ed0;
        logic        er0;
        logic [63:0] ed1;
        logic        er1;
        logic        eiss;
        logic [31:0] ebusy;
    } vec_t;

    vec_t tbl [16];

    function automatic vec_t row(input logic r, input logic ie_v, input logic [4:0] ir_v,
                                 input logic we_v, input logic [4:0] wr_v, input logic [63:0] wd_v,
                                 input logic [4:0] a0, input logic [4:0] a1,
                                 input logic [63:0] ed0, input logic er0,
                                 input logic [63:0] ed1, input logic er1,
                                 input logic eiss, input logic [31:0] ebusy);
        vec_t v;
        v.r = r; v.ie = ie_v; v.ir = ir_v; v.we = we_v; v.wr = wr_v; v.wd = wd_v;
        v.a0 = a0; v.a1 = a1; v.ed0 = ed0; v.er0 = er0; v.ed1 = ed1; v.er1 = er1;
        v.eiss = eiss; v.ebusy = ebusy;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // Reference model: reads, issue acceptance and state update from the rules.
    function automatic logic [63:0] exp_data(input logic [4:0] a, input bit byp);
        if (a == 0) return 64'd0;
        if (byp && we && wr == a) return wd;
        return m_data[a];
    endfunction

    function automatic logic exp_rdy(input logic [4:0] a, input bit byp);
        if (a == 0) return 1'b1;
        if (byp && we && wr == a) return 1'b1;
        return !m_busy[a];
    endfunction

    function automatic logic exp_iss();
        return (ir == 0) || !m_busy[ir] || (we && wr == ir);
    endfunction

    function automatic logic [31:0] exp_busy();
        logic [31:0] b;
        for (int i = 0; i < 32; i++) b[i] = m_busy[i];
        return b;
    endfunction

    task automatic model_step();
        logic acc;
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                m_data[i] = 64'd0;
                m_busy[i] = 1'b0;
            end
        end else begin
            acc = ie && exp_iss();
            if (we && wr != 0) begin
                m_data[wr] = wd;
                m_busy[wr] = 1'b0;
            end
            if (acc && ir != 0) m_busy[ir] = 1'b1;
        end
    endtask

    task automatic model_check(input string tag);
        logic [4:0] a;
        for (int p = 0; p < 2; p++) begin
            a = a_addr[p*5 +: 5];
            chk($sformatf("%s byp data p%0d x%0d", tag, p, a), a_data[p*64 +: 64], exp_data(a, 1'b1));
            chk($sformatf("%s byp rdy p%0d x%0d", tag, p, a), {63'd0, a_rdy[p]}, {63'd0, exp_rdy(a, 1'b1)});
        end
        for (int p = 0; p < 3; p++) begin
            a = n_addr[p*5 +: 5];
            chk($sformatf("%s nb data p%0d x%0d", tag, p, a), n_data[p*64 +: 64], exp_data(a, 1'b0));
            chk($sformatf("%s nb rdy p%0d x%0d", tag, p, a), {63'd0, n_rdy[p]}, {63'd0, exp_rdy(a, 1'b0)});
        end
        chk({tag, " byp issue_ready"}, {63'd0, a_iss}, {63'd0, exp_iss()});
        chk({tag, " nb issue_ready"}, {63'd0, n_iss}, {63'd0, exp_iss()});
        chk({tag, " byp busy"}, {32'd0, a_busy}, {32'd0, exp_busy()});
        chk({tag, " nb busy"}, {32'd0, n_busy}, {32'd0, exp_busy()});
    endtask

    task automatic drive(input logic r, input logic ie_v, input logic [4:0] ir_v,
                         input logic we_v, input logic [4:0] wr_v, input logic [63:0] wd_v);
        rst = r; ie = ie_v; ir = ir_v; we = we_v; wr = wr_v; wd = wd_v;
    endtask

    task automatic end_cycle();
        model_step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) begin
            m_data[i] = 64'd0;
            m_busy[i] = 1'b0;
        end
        drive(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 64'd0);
        a_addr = '0;
        n_addr = '0;
        repeat (2) @(posedge clk);
        #1;

        //            r  ie ir  we wr  wd            a0  a1  ed0           er0 ed1           er1 iss busy
        tbl[0]  = row(0, 0, 0,  0, 0,  64'h0,        5,  31, 64'h0,        1,  64'h0,        1,  1,  32'h0);
        tbl[1]  = row(0, 1, 7,  0, 0,  64'h0,        7,  5,  64'h0,        1,  64'h0,        1,  1,  32'h0);
        tbl[2]  = row(0, 0, 0,  0, 0,  64'h0,        7,  0,  64'h0,        0,  64'h0,        1,  1,  32'h80);
        tbl[3]  = row(0, 0, 0,  1, 7,  64'hDEADBEEF, 7,  7,  64'hDEADBEEF, 1,  64'hDEADBEEF, 1,  1,  32'h80);
        tbl[4]  = row(0, 0, 0,  0, 0,  64'h0,        7,  5,  64'hDEADBEEF, 1,  64'h0,        1,  1,  32'h0);
        tbl[5]  = row(0, 1, 9,  0, 0,  64'h0,        9,  7,  64'h0,        1,  64'hDEADBEEF, 1,  1,  32'h0);
        tbl[6]  = row(0, 1, 9,  0, 0,  64'h0,        9,  0,  64'h0,        0,  64'h0,        1,  0,  32'h200);
        tbl[7]  = row(0, 1, 9,  1, 9,  64'hCAFE,     9,  9,  64'hCAFE,     1,  64'hCAFE,     1,  1,  32'h200);
        tbl[8]  = row(0, 0, 0,  0, 0,  64'h0,        9,  0,  64'hCAFE,     0,  64'h0,        1,  1,  32'h200);
        tbl[9]  = row(0, 1, 0,  1, 0,  64'h1234,     0,  9,  64'h0,        1,  64'hCAFE,     0,  1,  32'h200);
        tbl[10] = row(0, 0, 0,  0, 0,  64'h0,        0,  0,  64'h0,        1,  64'h0,        1,  1,  32'h200);
        tbl[11] = row(0, 0, 0,  1, 4,  64'h44,       4,  5,  64'h44,       1,  64'h0,        1,  1,  32'h200);
        tbl[12] = row(0, 1, 4,  1, 5,  64'h55,       4,  5,  64'h44,       1,  64'h55,       1,  1,  32'h200);
        tbl[13] = row(0, 1, 5,  0, 0,  64'h0,        4,  5,  64'h44,       0,  64'h55,       1,  1,  32'h210);
        tbl[14] = row(1, 0, 0,  1, 4,  64'h99,       4,  5,  64'h99,       1,  64'h55,       0,  1,  32'h230);
        tbl[15] = row(0, 0, 0,  0, 0,  64'h0,        4,  5,  64'h0,        1,  64'h0,        1,  1,  32'h0);

        for (int i = 0; i < 16; i++) begin
            drive(tbl[i].r, tbl[i].ie, tbl[i].ir, tbl[i].we, tbl[i].wr, tbl[i].wd);
            a_addr = {tbl[i].a1, tbl[i].a0};
            n_addr = {tbl[i].a0, tbl[i].a1, tbl[i].a0};
            @(negedge clk);
            chk($sformatf("vec%0d data0", i), a_data[63:0], tbl[i].ed0);
            chk($sformatf("vec%0d data1", i), a_data[127:64], tbl[i].ed1);
            chk($sformatf("vec%0d rdy0", i), {63'd0, a_rdy[0]}, {63'd0, tbl[i].er0});
            chk($sformatf("vec%0d rdy1", i), {63'd0, a_rdy[1]}, {63'd0, tbl[i].er1});
            chk($sformatf("vec%0d issue_ready", i), {63'd0, a_iss}, {63'd0, tbl[i].eiss});
            chk($sformatf("vec%0d busy", i), {32'd0, a_busy}, {32'd0, tbl[i].ebusy});
            model_check($sformatf("vec%0d", i));
            end_cycle();
        end

        // Non-bypass, 3 ports all on x3: write-back is invisible until after the edge.
        n_addr = {5'd3, 5'd3, 5'd3};
        a_addr = {5'd3, 5'd3};
        drive(0, 0, 0, 1, 3, 64'h55);
        @(negedge clk);
        for (int p = 0; p < 3; p++) begin
            chk($sformatf("nb wb same-cycle data p%0d", p), n_data[p*64 +: 64], 64'h0);
            chk($sformatf("nb wb same-cycle rdy p%0d", p), {63'd0, n_rdy[p]}, 64'd1);
        end
        end_cycle();
        drive(0, 1, 3, 0, 0, 64'h0);
        @(negedge clk);
        for (int p = 0; p < 3; p++)
            chk($sformatf("nb wb next-cycle data p%0d", p), n_data[p*64 +: 64], 64'h55);
        end_cycle();
        drive(0, 0, 0, 1, 3, 64'h66);
        @(negedge clk);
        for (int p = 0; p < 3; p++) begin
            chk($sformatf("nb busy wb data p%0d", p), n_data[p*64 +: 64], 64'h55);
            chk($sformatf("nb busy wb rdy p%0d", p), {63'd0, n_rdy[p]}, 64'd0);
        end
        end_cycle();
        drive(0, 0, 0, 0, 0, 64'h0);
        @(negedge clk);
        for (int p = 0; p < 3; p++) begin
            chk($sformatf("nb after wb data p%0d", p), n_data[p*64 +: 64], 64'h66);
            chk($sformatf("nb after wb rdy p%0d", p), {63'd0, n_rdy[p]}, 64'd1);
        end
        end_cycle();

        // Randomized traffic on a small register window to provoke hazards.
        for (int c = 0; c < 400; c++) begin
            drive(($urandom_range(0, 59) == 0),
                  1'($urandom_range(0, 1)),
                  ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7)),
                  1'($urandom_range(0, 1)),
                  ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7)),
                  {$urandom, $urandom});
            for (int p = 0; p < 2; p++) a_addr[p*5 +: 5] = 5'($urandom_range(0, 7));
            for (int p = 0; p < 3; p++) n_addr[p*5 +: 5] = 5'($urandom_range(0, 7));
            @(negedge clk);
            model_check($sformatf("rnd%0d", c));
            end_cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
